// File: rtl/pong_engine.sv
// pong_engine: game-state core for the VGA pong design.
// Holds the ball, both paddles, both scores and the SERVE/PLAY/GAMEOVER
// state machine. Positions advance once per frame_tick (vblank strobe).
// Only screen-space coordinates and scores are produced; rendering,
// pixel and sync generation live elsewhere.
//
// Ports:
//   pclk, reset        clock, synchronous active-high reset
//   frame_tick         one-cycle update strobe
//   btns[3:0]          [0] p1 down, [1] p1 up, [2] p2 down, [3] p2 up
//   auto               paddle 2 AI request (only with AUTO_PADDLE_EN)
//   start              restart from GAMEOVER, sampled every cycle
//   ball_x, ball_y     ball top-left corner
//   paddle1_y/2_y      paddle top edges
//   score1, score2     scores
//   state              00 SERVE, 01 PLAY, 10 GAMEOVER
//   winner             0 = p1, 1 = p2 (meaningful in GAMEOVER)
//   hit, point         one-cycle pulses on paddle bounce / score
//
// Build option: define AUTO_PADDLE_EN to let auto = 1 steer paddle 2
// toward the ball instead of btns[3:2].
module pong_engine #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int PADDLE_W     = 10,
    parameter int PADDLE_H     = 60,
    parameter int PADDLE_LEFT  = 40,
    parameter int BALL_SIZE    = 6,
    parameter int BALL_SPX     = 2,
    parameter int BALL_SPY     = 3,
    parameter int PADDLE_SPEED = 4,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 7,
    parameter int SCORE_W      = 4
) (
    input  logic                        pclk,
    input  logic                        reset,
    input  logic                        frame_tick,
    input  logic [3:0]                  btns,
    input  logic                        auto,
    input  logic                        start,
    output logic [$clog2(SCREEN_W)-1:0] ball_x,
    output logic [$clog2(SCREEN_H)-1:0] ball_y,
    output logic [$clog2(SCREEN_H)-1:0] paddle1_y,
    output logic [$clog2(SCREEN_H)-1:0] paddle2_y,
    output logic [SCORE_W-1:0]          score1,
    output logic [SCORE_W-1:0]          score2,
    output logic [1:0]                  state,
    output logic                        winner,
    output logic                        hit,
    output logic                        point
);

    localparam int XW = $clog2(SCREEN_W);
    localparam int YW = $clog2(SCREEN_H);
    localparam int GX = XW + 1;   // guard bit so sums never wrap
    localparam int GY = YW + 1;
    localparam int CW = $clog2(SERVE_FRAMES + 1);

    localparam logic [GX-1:0] X_CEN  = GX'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [GY-1:0] Y_CEN  = GY'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [GY-1:0] P_CEN  = GY'((SCREEN_H - PADDLE_H) / 2);
    localparam logic [GY-1:0] P_MAX  = GY'(SCREEN_H - PADDLE_H);
    localparam logic [GY-1:0] P_SPD  = GY'(PADDLE_SPEED);
    localparam logic [GY-1:0] P_H    = GY'(PADDLE_H);
    localparam logic [GX-1:0] L_FACE = GX'(PADDLE_LEFT + PADDLE_W);
    localparam logic [GX-1:0] R_FACE = GX'(SCREEN_W - PADDLE_LEFT - PADDLE_W);
    localparam logic [GX-1:0] X_SIZE = GX'(BALL_SIZE);
    localparam logic [GY-1:0] Y_SIZE = GY'(BALL_SIZE);
    localparam logic [GX-1:0] X_SPD  = GX'(BALL_SPX);
    localparam logic [GY-1:0] Y_SPD  = GY'(BALL_SPY);
    localparam logic [GX-1:0] X_LIM  = GX'(SCREEN_W);
    localparam logic [GY-1:0] Y_LIM  = GY'(SCREEN_H);
    localparam logic [GY-1:0] Y_BOT  = GY'(SCREEN_H - BALL_SIZE);

    typedef enum logic [1:0] {
        S_SERVE = 2'b00,
        S_PLAY  = 2'b01,
        S_OVER  = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [XW-1:0]      bx_q, bx_d;
    logic [YW-1:0]      by_q, by_d;
    logic [YW-1:0]      p1_q, p1_d, p2_q, p2_d;
    logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               win_q, win_d;
    logic               dirx_q, dirx_d;   // 1 = moving right
    logic               diry_q, diry_d;   // 1 = moving down
    logic               hit_q, hit_d, point_q, point_d;

    logic [GY-1:0]      p1_nxt, p2_nxt;
    logic [GY-1:0]      ny;
    logic [GX-1:0]      xe;
    logic               ov1, ov2, miss_l, miss_r;

    function automatic logic [GY-1:0] pad_step(input logic [GY-1:0] p,
                                               input logic dn, input logic up);
        logic [GY-1:0] r;
        r = p;
        if (dn && !up)
            r = (p + P_SPD > P_MAX) ? P_MAX : p + P_SPD;
        else if (up && !dn)
            r = (p < P_SPD) ? '0 : p - P_SPD;
        return r;
    endfunction

    assign p1_nxt = pad_step({1'b0, p1_q}, btns[0], btns[1]);

`ifdef AUTO_PADDLE_EN
    // Chase a target that centres the paddle on the ball, landing exactly
    // on it once within one step.
    function automatic logic [GY-1:0] auto_step(input logic [GY-1:0] p,
                                                input logic [GY-1:0] by);
        logic [GY-1:0] c, t, r;
        c = by + GY'(BALL_SIZE / 2);
        t = (c < GY'(PADDLE_H / 2)) ? '0 : c - GY'(PADDLE_H / 2);
        if (t > P_MAX) t = P_MAX;
        if (t > p) r = (t - p < P_SPD) ? t : p + P_SPD;
        else       r = (p - t < P_SPD) ? t : p - P_SPD;
        return r;
    endfunction

    assign p2_nxt = auto ? auto_step({1'b0, p2_q}, {1'b0, by_q})
                         : pad_step({1'b0, p2_q}, btns[2], btns[3]);
`else
    logic unused_auto;
    assign unused_auto = auto;
    assign p2_nxt = pad_step({1'b0, p2_q}, btns[2], btns[3]);
`endif

    always_comb begin
        state_d = state_q;
        bx_d    = bx_q;
        by_d    = by_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        dirx_d  = dirx_q;
        diry_d  = diry_q;
        hit_d   = 1'b0;
        point_d = 1'b0;
        ny      = {1'b0, by_q};
        xe      = {1'b0, bx_q};
        ov1     = 1'b0;
        ov2     = 1'b0;
        miss_l  = 1'b0;
        miss_r  = 1'b0;

        if (frame_tick) begin
            p1_d = YW'(p1_nxt);
            p2_d = YW'(p2_nxt);
            case (state_q)
                S_SERVE: begin
                    bx_d = XW'(X_CEN);
                    by_d = YW'(Y_CEN);
                    if (cnt_q == CW'(SERVE_FRAMES - 1)) begin
                        state_d = S_PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_PLAY: begin
                    if (diry_q) begin
                        if (ny + Y_SIZE + Y_SPD > Y_LIM) begin
                            ny     = Y_BOT;
                            diry_d = 1'b0;
                        end else begin
                            ny = ny + Y_SPD;
                        end
                    end else begin
                        if (ny < Y_SPD) begin
                            ny     = '0;
                            diry_d = 1'b1;
                        end else begin
                            ny = ny - Y_SPD;
                        end
                    end
                    by_d = YW'(ny);
                    // Paddle overlap uses the moved ball and moved paddles.
                    ov1 = (ny + Y_SIZE > p1_nxt) && (ny < p1_nxt + P_H);
                    ov2 = (ny + Y_SIZE > p2_nxt) && (ny < p2_nxt + P_H);

                    if (!dirx_q) begin
                        if (xe >= L_FACE && xe - X_SPD < L_FACE && ov1) begin
                            bx_d   = XW'(L_FACE);
                            dirx_d = 1'b1;
                            hit_d  = 1'b1;
                        end else if (xe < X_SPD) begin
                            miss_l = 1'b1;
                        end else begin
                            bx_d = XW'(xe - X_SPD);
                        end
                    end else begin
                        if (xe + X_SIZE <= R_FACE && xe + X_SIZE + X_SPD > R_FACE && ov2) begin
                            bx_d   = XW'(R_FACE - X_SIZE);
                            dirx_d = 1'b0;
                            hit_d  = 1'b1;
                        end else if (xe + X_SIZE + X_SPD > X_LIM) begin
                            miss_r = 1'b1;
                        end else begin
                            bx_d = XW'(xe + X_SPD);
                        end
                    end

                    if (miss_l || miss_r) begin
                        bx_d    = XW'(X_CEN);
                        by_d    = YW'(Y_CEN);
                        point_d = 1'b1;
                        // Left miss scores for p2, so the serve heads right.
                        dirx_d  = miss_l;
                        state_d = S_SERVE;
                        if (miss_l) begin
                            s2_d = s2_q + SCORE_W'(1);
                            if (s2_d == SCORE_W'(WIN_SCORE)) begin
                                state_d = S_OVER;
                                win_d   = 1'b1;
                            end
                        end else begin
                            s1_d = s1_q + SCORE_W'(1);
                            if (s1_d == SCORE_W'(WIN_SCORE)) begin
                                state_d = S_OVER;
                                win_d   = 1'b0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end

        // start is honoured on any cycle, tick or not.
        if (state_q == S_OVER && start) begin
            s1_d    = '0;
            s2_d    = '0;
            dirx_d  = 1'b0;
            cnt_d   = '0;
            state_d = S_SERVE;
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q <= S_SERVE;
            bx_q    <= XW'(X_CEN);
            by_q    <= YW'(Y_CEN);
            p1_q    <= YW'(P_CEN);
            p2_q    <= YW'(P_CEN);
            s1_q    <= '0;
            s2_q    <= '0;
            cnt_q   <= '0;
            win_q   <= 1'b0;
            dirx_q  <= 1'b0;
            diry_q  <= 1'b1;
            hit_q   <= 1'b0;
            point_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            dirx_q  <= dirx_d;
            diry_q  <= diry_d;
            hit_q   <= hit_d;
            point_q <= point_d;
        end
    end

    assign ball_x    = bx_q;
    assign ball_y    = by_q;
    assign paddle1_y = p1_q;
    assign paddle2_y = p2_q;
    assign score1    = s1_q;
    assign score2    = s2_q;
    assign state     = state_q;
    assign winner    = win_q;
    assign hit       = hit_q;
    assign point     = point_q;

endmodule

// File: tb/tb_pong_engine.sv
// Testbench for pong_engine with default parameters. A behavioural model
// of the game rules (plain integers) predicts every output after each
// clock; scenario tasks also check the fixed values of the game plan.
module tb_pong_engine;

    logic       pclk;
    logic       reset;
    logic       frame_tick;
    logic [3:0] btns;
    logic       auto;
    logic       start;
    logic [9:0] ball_x;
    logic [8:0] ball_y, paddle1_y, paddle2_y;
    logic [3:0] score1, score2;
    logic [1:0] state;
    logic       winner, hit, point;

    int checks = 0;
    int errors = 0;

    // model state: st 0 SERVE 1 PLAY 2 GAMEOVER
    int m_st, m_bx, m_by, m_p1, m_p2, m_s1, m_s2, m_win, m_hit, m_pt, m_cnt, m_dxr, m_dyd;

    pong_engine dut (
        .pclk(pclk), .reset(reset), .frame_tick(frame_tick), .btns(btns),
        .auto(auto), .start(start), .ball_x(ball_x), .ball_y(ball_y),
        .paddle1_y(paddle1_y), .paddle2_y(paddle2_y), .score1(score1),
        .score2(score2), .state(state), .winner(winner), .hit(hit), .point(point)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    function automatic int pad_move(int p, logic dn, logic up);
        if (dn && !up) return (p + 4 > 420) ? 420 : p + 4;
        if (up && !dn) return (p < 4) ? 0 : p - 4;
        return p;
    endfunction

    function automatic int auto_move(int p, int by);
        int t;
        t = by + 3 - 30;
        if (t < 0) t = 0;
        if (t > 420) t = 420;
        if (t - p < 4 && p - t < 4) return t;
        return (t > p) ? p + 4 : p - 4;
    endfunction

    function automatic logic overlaps(int y, int p);
        return (y + 6 > p) && (y < p + 60);
    endfunction

    task automatic model_edge(input logic rst, input logic tk, input logic [3:0] b, input logic st);
        int np1, np2, ny, pre, scorer;
        m_hit = 0;
        m_pt  = 0;
        if (rst) begin
            m_st = 0; m_bx = 317; m_by = 237; m_p1 = 210; m_p2 = 210;
            m_s1 = 0; m_s2 = 0; m_win = 0; m_cnt = 0; m_dxr = 0; m_dyd = 1;
            return;
        end
        pre = m_st;
        if (tk) begin
            np1 = pad_move(m_p1, b[0], b[1]);
            np2 = pad_move(m_p2, b[2], b[3]);
`ifdef AUTO_PADDLE_EN
            if (auto) np2 = auto_move(m_p2, m_by);
`endif
            if (m_st == 0) begin
                if (m_cnt == 59) begin m_st = 1; m_cnt = 0; end
                else m_cnt++;
            end else if (m_st == 1) begin
                if (m_dyd != 0) begin
                    if (m_by + 9 > 480) begin ny = 474; m_dyd = 0; end
                    else ny = m_by + 3;
                end else begin
                    if (m_by < 3) begin ny = 0; m_dyd = 1; end
                    else ny = m_by - 3;
                end
                m_by = ny;
                scorer = 0;
                if (m_dxr == 0) begin
                    if (m_bx >= 50 && m_bx - 2 < 50 && overlaps(ny, np1)) begin
                        m_bx = 50; m_dxr = 1; m_hit = 1;
                    end else if (m_bx < 2) scorer = 2;
                    else m_bx = m_bx - 2;
                end else begin
                    if (m_bx + 6 <= 590 && m_bx + 8 > 590 && overlaps(ny, np2)) begin
                        m_bx = 584; m_dxr = 0; m_hit = 1;
                    end else if (m_bx + 8 > 640) scorer = 1;
                    else m_bx = m_bx + 2;
                end
                if (scorer != 0) begin
                    m_pt = 1; m_bx = 317; m_by = 237;
                    m_dxr = (scorer == 2) ? 1 : 0;
                    m_st = 0;
                    if (scorer == 2) begin
                        m_s2++;
                        if (m_s2 == 7) begin m_st = 2; m_win = 1; end
                    end else begin
                        m_s1++;
                        if (m_s1 == 7) begin m_st = 2; m_win = 0; end
                    end
                end
            end
            m_p1 = np1;
            m_p2 = np2;
        end
        if (pre == 2 && st) begin
            m_s1 = 0; m_s2 = 0; m_dxr = 0; m_cnt = 0; m_st = 0;
        end
    endtask

    task automatic step(input logic rst, input logic tk, input logic [3:0] b, input logic st);
        reset = rst; frame_tick = tk; btns = b; start = st;
        @(posedge pclk);
        model_edge(rst, tk, b, st);
        #1;
    endtask

    function automatic logic [49:0] dut_vec();
        return {ball_x, ball_y, paddle1_y, paddle2_y, score1, score2, state, winner, hit, point};
    endfunction

    function automatic logic [49:0] mdl_vec();
        return {10'(m_bx), 9'(m_by), 9'(m_p1), 9'(m_p2), 4'(m_s1), 4'(m_s2),
                2'(m_st), 1'(m_win), 1'(m_hit), 1'(m_pt)};
    endfunction

    function automatic logic [3:0] track_btns(logic p2_track, logic p1_track, logic p1_away);
        logic [3:0] b;
        int c;
        b = 4'b0000;
        c = m_by + 3;
        if (p2_track) begin
            if (c > m_p2 + 31) b[2] = 1'b1;
            else if (c < m_p2 + 29) b[3] = 1'b1;
        end
        if (p1_track) begin
            if (c > m_p1 + 31) b[0] = 1'b1;
            else if (c < m_p1 + 29) b[1] = 1'b1;
        end else if (p1_away) begin
            if (c < 240) b[0] = 1'b1;
            else b[1] = 1'b1;
        end
        return b;
    endfunction

    task automatic test_reset();
        step(1, 0, 4'b0, 0);
        step(1, 1, 4'b1111, 0);
        checks++;
        if (dut_vec() !== {10'd317, 9'd237, 9'd210, 9'd210, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values got %h expected %h", dut_vec(),
                     {10'd317, 9'd237, 9'd210, 9'd210, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0});
        end
        step(0, 1, 4'b0, 0);
        checks++;
        if (dut_vec() !== mdl_vec() || state !== 2'b00 || ball_x !== 10'd317) begin
            errors++;
            $display("FAIL reset_first_tick got %h expected %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_serve();
        step(1, 0, 4'b0, 0);
        for (int i = 1; i <= 60; i++) begin
            for (int k = 0; k < int'($urandom_range(2)); k++) begin
                step(0, 0, 4'($urandom), 1'($urandom));
                checks++;
                if (dut_vec() !== mdl_vec()) begin
                    errors++;
                    $display("FAIL serve_idle got %h expected %h", dut_vec(), mdl_vec());
                end
            end
            step(0, 1, 4'b0, 0);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL serve_tick%0d got %h expected %h", i, dut_vec(), mdl_vec());
            end
            if (i == 59) begin
                checks++;
                if (state !== 2'b00) begin
                    errors++;
                    $display("FAIL serve_tick59_state got %0d expected 0", state);
                end
            end
        end
        checks++;
        if (state !== 2'b01 || ball_x !== 10'd317 || ball_y !== 9'd237) begin
            errors++;
            $display("FAIL serve_to_play got st=%0d (%0d,%0d) expected st=1 (317,237)", state, ball_x, ball_y);
        end
        step(0, 1, 4'b0, 0);
        checks++;
        if (ball_x !== 10'd315 || ball_y !== 9'd240) begin
            errors++;
            $display("FAIL first_move got (%0d,%0d) expected (315,240)", ball_x, ball_y);
        end
    endtask

    task automatic test_paddles();
        step(1, 0, 4'b0, 0);
        for (int i = 0; i < 60; i++) begin
            step(0, 1, 4'b0101, 0);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL paddle_down got %h expected %h", dut_vec(), mdl_vec());
            end
        end
        checks++;
        if (paddle1_y !== 9'd420 || paddle2_y !== 9'd420) begin
            errors++;
            $display("FAIL paddle_clamp_bottom got %0d/%0d expected 420/420", paddle1_y, paddle2_y);
        end
        for (int i = 0; i < 5; i++) step(0, 1, 4'b1111, 0);
        checks++;
        if (paddle1_y !== 9'd420 || paddle2_y !== 9'd420) begin
            errors++;
            $display("FAIL paddle_both_btns got %0d/%0d expected 420/420", paddle1_y, paddle2_y);
        end
        for (int i = 0; i < 120; i++) step(0, 1, 4'b1010, 0);
        checks++;
        if (paddle1_y !== 9'd0 || paddle2_y !== 9'd0 || dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL paddle_clamp_top got %0d/%0d expected 0/0", paddle1_y, paddle2_y);
        end
    endtask

    task automatic test_wall_miss();
        int n;
        logic found;
        step(1, 0, 4'b0, 0);
        found = 0;
        n = 0;
        while (!found && n < 400) begin
            step(0, 1, 4'b0, 0);
            n++;
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL descend got %h expected %h", dut_vec(), mdl_vec());
            end
            if (m_st == 1 && m_by == 474) found = 1;
        end
        checks++;
        if (!found || ball_y !== 9'd474) begin
            errors++;
            $display("FAIL reach_bottom got y=%0d expected 474 within 400 ticks", ball_y);
        end
        step(0, 1, 4'b0, 0);
        checks++;
        if (ball_y !== 9'd474) begin
            errors++;
            $display("FAIL bottom_bounce got y=%0d expected 474", ball_y);
        end
        step(0, 1, 4'b0, 0);
        checks++;
        if (ball_y !== 9'd471) begin
            errors++;
            $display("FAIL bounce_up got y=%0d expected 471", ball_y);
        end
        n = 0;
        while (m_pt == 0 && n < 500) begin
            step(0, 1, 4'b0, 0);
            n++;
        end
        checks++;
        if (m_pt == 0 || point !== 1'b1 || score2 !== 4'd1 || score1 !== 4'd0 ||
            state !== 2'b00 || ball_x !== 10'd317 || ball_y !== 9'd237) begin
            errors++;
            $display("FAIL left_miss got pt=%0d s=%0d/%0d st=%0d (%0d,%0d) expected pt=1 s=0/1 st=0 (317,237)",
                     point, score1, score2, state, ball_x, ball_y);
        end
        step(0, 1, 4'b0, 0);
        checks++;
        if (point !== 1'b0 || dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL point_pulse_width got %h expected %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_hit_reset();
        int n;
        step(1, 0, 4'b0, 0);
        n = 0;
        while (m_hit == 0 && n < 600) begin
            step(0, 1, track_btns(0, 1, 0), 0);
            n++;
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL approach got %h expected %h", dut_vec(), mdl_vec());
            end
        end
        checks++;
        if (m_hit == 0 || hit !== 1'b1 || ball_x !== 10'd50) begin
            errors++;
            $display("FAIL paddle1_hit got hit=%0d x=%0d expected hit=1 x=50", hit, ball_x);
        end
        step(0, 1, 4'b0, 0);
        checks++;
        if (hit !== 1'b0 || ball_x !== 10'd52) begin
            errors++;
            $display("FAIL after_hit got hit=%0d x=%0d expected hit=0 x=52", hit, ball_x);
        end
        step(1, 1, 4'b0101, 0);
        checks++;
        if (dut_vec() !== {10'd317, 9'd237, 9'd210, 9'd210, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_play got %h expected %h", dut_vec(),
                     {10'd317, 9'd237, 9'd210, 9'd210, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_gameover();
        int n;
        logic [9:0] fx;
        logic [8:0] fy;
        step(1, 0, 4'b0, 0);
        n = 0;
        while (m_st != 2 && n < 20000) begin
            step(0, 1, track_btns(1, 0, 1), 0);
            n++;
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL rally got %h expected %h", dut_vec(), mdl_vec());
            end
        end
        checks++;
        if (state !== 2'b10 || winner !== 1'b1 || score2 !== 4'd7) begin
            errors++;
            $display("FAIL gameover got st=%0d win=%0d s2=%0d expected st=2 win=1 s2=7", state, winner, score2);
        end
        fx = ball_x;
        fy = ball_y;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 4'($urandom), 0);
            checks++;
            if (ball_x !== fx || ball_y !== fy || dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL ball_frozen got (%0d,%0d) expected (%0d,%0d)", ball_x, ball_y, fx, fy);
            end
        end
        step(0, 0, 4'b0, 1);
        checks++;
        if (state !== 2'b00 || score1 !== 4'd0 || score2 !== 4'd0 || dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL restart got st=%0d s=%0d/%0d expected st=0 s=0/0", state, score1, score2);
        end
        step(0, 0, 4'b0, 0);
    endtask

`ifdef AUTO_PADDLE_EN
    task automatic test_auto();
        step(1, 0, 4'b0, 0);
        auto = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            step(0, 1, {2'($urandom), track_btns(0, 1, 0)}, 0);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL auto_track got %h expected %h", dut_vec(), mdl_vec());
            end
        end
        checks++;
        if (score1 !== 4'd0) begin
            errors++;
            $display("FAIL auto_never_missed got score1=%0d expected 0", score1);
        end
        auto = 1'b0;
    endtask
`endif

    task automatic test_random();
        step(1, 0, 4'b0, 0);
        for (int i = 0; i < 4000; i++) begin
            auto = 1'($urandom);
            step(($urandom_range(399) == 0), ($urandom_range(3) != 0), 4'($urandom),
                 ($urandom_range(19) == 0));
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL random_cycle%0d got %h expected %h", i, dut_vec(), mdl_vec());
            end
        end
        auto = 1'b0;
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; btns = 4'b0; auto = 1'b0; start = 1'b0;
        model_edge(1, 0, 4'b0, 0);
        test_reset();
        test_serve();
        test_paddles();
        test_wall_miss();
        test_hit_reset();
        test_gameover();
`ifdef AUTO_PADDLE_EN
        test_auto();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
